// File: rtl/omsp_spm_key_loader_if.sv
`default_nettype none
//==============================================================================
// Module   : omsp_spm_key_loader_if
// Purpose  : Request/stream handshake between the SM key loader and the
//            key-derivation engine.
// Signals  : kdf_req   - key-derivation request (loader -> engine)
//            kdf_id    - SM id the key is derived for (loader -> engine)
//            kdf_ready - engine accepted the request (engine -> loader)
//            kdf_valid - kdf_data carries the next key word (engine -> loader)
//            kdf_data  - 16-bit key word, MS word first (engine -> loader)
// Modports : master = loader side, slave = engine side
// Revision : 1.0 - initial release
//==============================================================================
interface omsp_spm_key_loader_if;
   logic        kdf_req;
   logic [15:0] kdf_id;
   logic        kdf_ready;
   logic        kdf_valid;
   logic [15:0] kdf_data;

   modport master (
      output kdf_req,
      output kdf_id,
      input  kdf_ready,
      input  kdf_valid,
      input  kdf_data
   );

   modport slave (
      input  kdf_req,
      input  kdf_id,
      output kdf_ready,
      output kdf_valid,
      output kdf_data
   );
endinterface
`default_nettype wire

// File: rtl/omsp_spm_key_loader.sv
`default_nettype none
//==============================================================================
// Module   : omsp_spm_key_loader
// Purpose  : Installs a freshly derived key into a newly enabled Sancus SM.
//            On start it requests a key from the KDF engine, accepts the key
//            as 16-bit words (MS word first) and writes each word into the SM
//            array, keeping the CPU stalled (busy) for the whole load.
// Ports    : mclk, puc_rst_n      - clock, async active-low reset
//            start, start_id      - load request and SM id (sampled in IDLE)
//            abort                - cancels a load in progress
//            kdf (master modport) - request/stream handshake with the KDF
//            write_key, key_in,
//            key_idx              - one-word write port to the SM array
//            busy, done, error    - CPU stall, success pulse, timeout pulse
// Revision : 1.0 - initial release
//==============================================================================
module omsp_spm_key_loader #(
   parameter int SECURITY     = 64,
   parameter int KEY_IDX_SIZE = 2,
   parameter int TIMEOUT      = 255
) (
   input  logic                    mclk,
   input  logic                    puc_rst_n,
   input  logic                    start,
   input  logic [15:0]             start_id,
   input  logic                    abort,
   omsp_spm_key_loader_if.master   kdf,
   output logic                    write_key,
   output logic [15:0]             key_in,
   output logic [KEY_IDX_SIZE-1:0] key_idx,
   output logic                    busy,
   output logic                    done,
   output logic                    error
);

   localparam int                    WORDS     = SECURITY / 16;
   localparam logic [KEY_IDX_SIZE:0] LAST_WORD = (KEY_IDX_SIZE+1)'(WORDS - 1);
   localparam logic [15:0]           TMO_LAST  = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_STREAM = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [KEY_IDX_SIZE:0] r_count, w_count_nxt;
   logic [15:0]           r_tmo, w_tmo_nxt;
   logic                  w_tmo_hit;

   logic                    w_kdf_req_nxt;
   logic [15:0]             w_kdf_id_nxt;
   logic                    w_write_key_nxt;
   logic [15:0]             w_key_in_nxt;
   logic [KEY_IDX_SIZE-1:0] w_key_idx_nxt;
   logic                    w_busy_nxt;
   logic                    w_done_nxt;
   logic                    w_error_nxt;

   always_ff @(posedge mclk or negedge puc_rst_n) begin
      if (!puc_rst_n) begin
         r_state     <= ST_IDLE;
         r_count     <= '0;
         r_tmo       <= '0;
         kdf.kdf_req <= 1'b0;
         kdf.kdf_id  <= '0;
         write_key   <= 1'b0;
         key_in      <= '0;
         key_idx     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_count     <= w_count_nxt;
         r_tmo       <= w_tmo_nxt;
         kdf.kdf_req <= w_kdf_req_nxt;
         kdf.kdf_id  <= w_kdf_id_nxt;
         write_key   <= w_write_key_nxt;
         key_in      <= w_key_in_nxt;
         key_idx     <= w_key_idx_nxt;
         busy        <= w_busy_nxt;
         done        <= w_done_nxt;
         error       <= w_error_nxt;
      end
   end

   // Idle-cycle budget exhausted; checked ahead of any handshake so that a
   // late ready/valid cannot extend a load past TIMEOUT.
   assign w_tmo_hit = (r_tmo == TMO_LAST);

   always_comb begin
      w_state_nxt     = r_state;
      w_count_nxt     = r_count;
      w_tmo_nxt       = r_tmo;
      w_kdf_id_nxt    = kdf.kdf_id;
      w_key_in_nxt    = key_in;
      w_key_idx_nxt   = key_idx;
      w_write_key_nxt = 1'b0;
      w_done_nxt      = 1'b0;
      w_error_nxt     = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (start && !abort) begin
               w_state_nxt  = ST_REQ;
               w_kdf_id_nxt = start_id;
               w_count_nxt  = '0;
               w_tmo_nxt    = '0;
            end
         end
         ST_REQ: begin
            // kdf_valid is deliberately ignored here, even alongside kdf_ready
            if (abort) begin
               w_state_nxt = ST_IDLE;
            end else if (w_tmo_hit) begin
               w_state_nxt = ST_IDLE;
               w_error_nxt = 1'b1;
            end else begin
               w_tmo_nxt = r_tmo + 16'd1;
               if (kdf.kdf_ready) begin
                  w_state_nxt = ST_STREAM;
               end
            end
         end
         ST_STREAM: begin
            if (abort) begin
               w_state_nxt = ST_IDLE;
            end else if (w_tmo_hit) begin
               w_state_nxt = ST_IDLE;
               w_error_nxt = 1'b1;
            end else if (kdf.kdf_valid) begin
               w_write_key_nxt = 1'b1;
               w_key_in_nxt    = kdf.kdf_data;
               w_key_idx_nxt   = r_count[KEY_IDX_SIZE-1:0];
               w_count_nxt     = r_count + 1'b1;
               w_tmo_nxt       = '0;
               // Leaving on the last word means the counter never wraps
               if (r_count == LAST_WORD) begin
                  w_state_nxt = ST_DONE;
               end
            end else begin
               w_tmo_nxt = r_tmo + 16'd1;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = !abort;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // Registered versions follow the next state so they change on the same
      // edge as the state itself.
      w_busy_nxt    = (w_state_nxt != ST_IDLE);
      w_kdf_req_nxt = (w_state_nxt == ST_REQ);
   end

endmodule
`default_nettype wire

// File: tb/tb_omsp_spm_key_loader.sv
`default_nettype none
//==============================================================================
// Module   : tb_omsp_spm_key_loader
// Purpose  : Self-checking bench for omsp_spm_key_loader. Each load is
//            described by a ready delay, per-word gaps, data and optional
//            abort; expected write/done/error edges are derived from the
//            timeout and abort rules and compared with what the DUT emits.
// Revision : 1.0 - initial release
//==============================================================================
module tb_omsp_spm_key_loader;
   localparam int SECURITY     = 64;
   localparam int KEY_IDX_SIZE = 2;
   localparam int TIMEOUT      = 8;
   localparam int WORDS        = SECURITY / 16;
   localparam int NSLOT        = 64;

   logic                    mclk = 1'b0;
   logic                    puc_rst_n = 1'b0;
   logic                    start = 1'b0;
   logic [15:0]             start_id = 16'h0;
   logic                    abort = 1'b0;
   logic                    write_key;
   logic [15:0]             key_in;
   logic [KEY_IDX_SIZE-1:0] key_idx;
   logic                    busy;
   logic                    done;
   logic                    error;

   omsp_spm_key_loader_if kif ();

   omsp_spm_key_loader #(
      .SECURITY     (SECURITY),
      .KEY_IDX_SIZE (KEY_IDX_SIZE),
      .TIMEOUT      (TIMEOUT)
   ) dut (
      .mclk      (mclk),
      .puc_rst_n (puc_rst_n),
      .start     (start),
      .start_id  (start_id),
      .abort     (abort),
      .kdf       (kif),
      .write_key (write_key),
      .key_in    (key_in),
      .key_idx   (key_idx),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   always #5 mclk = ~mclk;

   int cyc = 0;
   always @(posedge mclk) cyc <= cyc + 1;

   // Event monitor: absolute edge number after which each output was high
   int          obs_wt[$];
   int          obs_wi[$];
   logic [15:0] obs_wd[$];
   int          obs_dt[$];
   int          obs_et[$];

   always @(negedge mclk) begin
      if (write_key) begin
         obs_wt.push_back(cyc);
         obs_wi.push_back(int'(key_idx));
         obs_wd.push_back(key_in);
      end
      if (done)  obs_dt.push_back(cyc);
      if (error) obs_et.push_back(cyc);
   end

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Current load description
   logic [15:0] t_id;
   int          t_d;
   int          t_gap  [WORDS];
   logic [15:0] t_data [WORDS];
   bit          t_spur;
   bit          t_vready;
   int          t_abort_kind;   // 0 none, 1 random edge, 2 right after t_abort_k words
   int          t_abort_k;
   int          e0;

   task automatic set_nominal(input logic [15:0] id);
      t_id = id;
      t_d  = 2;
      for (int i = 0; i < WORDS; i++) begin
         t_gap[i]  = 0;
         t_data[i] = 16'h1111 * 16'(i + 1);
      end
      t_spur       = 1'b0;
      t_vready     = 1'b0;
      t_abort_kind = 0;
      t_abort_k    = 0;
   endtask

   task automatic run_load(input string name);
      int          wedge [WORDS];
      int          exp_t [WORDS];
      int          exp_n, done_off, err_off, end_off, a_off, req_end, busy_end;
      int          last_clear, n_off, e;
      bit          sv [NSLOT];
      logic [15:0] sd [NSLOT];

      // Planned edges (relative to the start edge) at which words are offered
      wedge[0] = t_d + 1 + t_gap[0];
      for (int i = 1; i < WORDS; i++) wedge[i] = wedge[i-1] + 1 + t_gap[i];

      // Outcome: a timeout fires TIMEOUT edges after the last clear point
      // (start edge or accepted word) unless progress happens before then.
      exp_n = 0; done_off = -1; err_off = -1; last_clear = 0;
      if (t_d >= TIMEOUT) begin
         err_off = TIMEOUT;
      end else begin
         for (int i = 0; i < WORDS; i++) begin
            if (err_off < 0) begin
               if (wedge[i] - last_clear >= TIMEOUT) begin
                  err_off = last_clear + TIMEOUT;
               end else begin
                  exp_t[i]   = wedge[i];
                  exp_n      = exp_n + 1;
                  last_clear = wedge[i];
               end
            end
         end
         if (exp_n == WORDS) done_off = wedge[WORDS-1] + 1;
      end
      end_off = (done_off >= 0) ? done_off : err_off;

      a_off = -1;
      if (t_abort_kind == 1)      a_off = int'($urandom_range(end_off, 2));
      else if (t_abort_kind == 2) a_off = wedge[t_abort_k-1] + 1;
      if (a_off >= 0) begin
         while (exp_n > 0 && exp_t[exp_n-1] >= a_off) exp_n = exp_n - 1;
         if (done_off >= a_off) done_off = -1;
         if (err_off  >= a_off) err_off  = -1;
      end

      busy_end = (a_off >= 0 && a_off < end_off) ? a_off : end_off;
      req_end  = (t_d < TIMEOUT) ? t_d : TIMEOUT;
      if (a_off >= 0 && a_off < req_end) req_end = a_off;

      for (int s = 0; s < NSLOT; s++) begin
         sv[s] = 1'b0;
         sd[s] = 16'($urandom);
      end
      for (int i = 0; i < WORDS; i++) begin
         if (wedge[i] < NSLOT) begin
            sv[wedge[i]] = 1'b1;
            sd[wedge[i]] = t_data[i];
         end
      end
      if (t_vready && t_d < NSLOT) sv[t_d] = 1'b1;

      n_off = end_off + 4;
      for (int off = 0; off < n_off; off++) begin
         @(negedge mclk);
         if (off == 0) begin
            e0 = cyc + 1;
         end else begin
            e = off - 1;
            check($sformatf("%s busy@%0d", name, e), 32'(busy), 32'(e < busy_end));
            check($sformatf("%s kdf_req@%0d", name, e), 32'(kif.kdf_req), 32'(e < req_end));
            if (e < busy_end)
               check($sformatf("%s kdf_id@%0d", name, e), 32'(kif.kdf_id), 32'(t_id));
         end
         start         = (off == 0) || (t_spur && off == 1);
         start_id      = (off == 0) ? t_id : ((t_spur && off == 1) ? 16'h0009 : 16'($urandom));
         kif.kdf_ready = (off == t_d);
         kif.kdf_valid = sv[off];
         kif.kdf_data  = sd[off];
         abort         = (off == a_off);
      end
      @(negedge mclk);
      start = 1'b0; abort = 1'b0;
      kif.kdf_ready = 1'b0; kif.kdf_valid = 1'b0;

      check($sformatf("%s n_writes", name), 32'(obs_wt.size()), 32'(exp_n));
      for (int i = 0; i < exp_n && i < obs_wt.size(); i++) begin
         check($sformatf("%s w%0d edge", name, i), 32'(obs_wt[i] - e0), 32'(exp_t[i]));
         check($sformatf("%s w%0d idx", name, i),  32'(obs_wi[i]), 32'(i));
         check($sformatf("%s w%0d data", name, i), 32'(obs_wd[i]), 32'(t_data[i]));
      end
      check($sformatf("%s n_done", name), 32'(obs_dt.size()), 32'((done_off >= 0) ? 1 : 0));
      if (done_off >= 0 && obs_dt.size() > 0)
         check($sformatf("%s done edge", name), 32'(obs_dt[0] - e0), 32'(done_off));
      check($sformatf("%s n_error", name), 32'(obs_et.size()), 32'((err_off >= 0) ? 1 : 0));
      if (err_off >= 0 && obs_et.size() > 0)
         check($sformatf("%s error edge", name), 32'(obs_et[0] - e0), 32'(err_off));

      obs_wt.delete(); obs_wi.delete(); obs_wd.delete();
      obs_dt.delete(); obs_et.delete();
   endtask

   task automatic check_all_zero(input string name);
      check({name, " write_key"}, 32'(write_key), 32'd0);
      check({name, " key_in"},    32'(key_in), 32'd0);
      check({name, " key_idx"},   32'(key_idx), 32'd0);
      check({name, " busy"},      32'(busy), 32'd0);
      check({name, " done"},      32'(done), 32'd0);
      check({name, " error"},     32'(error), 32'd0);
      check({name, " kdf_req"},   32'(kif.kdf_req), 32'd0);
      check({name, " kdf_id"},    32'(kif.kdf_id), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      kif.kdf_ready = 1'b0;
      kif.kdf_valid = 1'b0;
      kif.kdf_data  = 16'h0;

      repeat (3) @(negedge mclk);
      check_all_zero("reset");
      puc_rst_n = 1'b1;
      repeat (2) @(negedge mclk);
      check_all_zero("post_reset");

      set_nominal(16'h0003);
      run_load("nominal");

      set_nominal(16'h0007);
      t_gap[1] = 3;
      run_load("gapped");

      set_nominal(16'h0011);
      t_d = 100;
      run_load("timeout");

      set_nominal(16'h0021);
      t_abort_kind = 2;
      t_abort_k    = 2;
      run_load("abort");
      set_nominal(16'h0004);
      run_load("after_abort");

      set_nominal(16'h0031);
      t_spur   = 1'b1;
      t_vready = 1'b1;
      run_load("ignored");

      // Reset in the middle of a stream, one word already written
      @(negedge mclk); start = 1'b1; start_id = 16'h0005;
      @(negedge mclk); start = 1'b0; kif.kdf_ready = 1'b1;
      @(negedge mclk); kif.kdf_ready = 1'b0; kif.kdf_valid = 1'b1; kif.kdf_data = 16'hABCD;
      @(negedge mclk); kif.kdf_valid = 1'b0;
      check("rst_mid first write", 32'(write_key), 32'd1);
      check("rst_mid first data",  32'(key_in), 32'h0000ABCD);
      @(posedge mclk);
      #2;
      puc_rst_n = 1'b0;
      #1;
      check_all_zero("rst_mid async");
      @(negedge mclk); puc_rst_n = 1'b1;
      @(negedge mclk);
      check_all_zero("rst_mid release");
      obs_wt.delete(); obs_wi.delete(); obs_wd.delete();
      obs_dt.delete(); obs_et.delete();

      for (int n = 0; n < 40; n++) begin
         t_id = 16'($urandom);
         if ($urandom_range(5, 0) == 0) t_d = int'($urandom_range(TIMEOUT + 2, TIMEOUT));
         else                           t_d = int'($urandom_range(TIMEOUT - 1, 1));
         for (int i = 0; i < WORDS; i++) begin
            t_gap[i]  = ($urandom_range(9, 0) < 8) ? int'($urandom_range(2, 0))
                                                   : int'($urandom_range(TIMEOUT, 0));
            t_data[i] = 16'($urandom);
         end
         t_spur       = ($urandom_range(3, 0) == 0);
         t_vready     = ($urandom_range(3, 0) == 0);
         t_abort_kind = ($urandom_range(4, 0) == 0) ? 1 : 0;
         t_abort_k    = 0;
         run_load($sformatf("rnd%0d", n));
         repeat ($urandom_range(2, 0)) @(negedge mclk);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
